regset_bus_sequencer: RTL and testbench
=======================================

# regset_bus_sequencer

Initiator side of the register-set bus protocol: accepts register-transfer micro-ops over a valid/ready handshake and sequences the active-low output-enable, bus-select and write-enable strobes that the register set and the external bus transmitter consume. Enforces drive-before-write and hold-after-write ordering, so each destination register samples a settled bus value. Sits between the control unit and the register set.

## Interface
- SETTLE_CYCLES, 1, cycles the bus is driven before the write strobe; legal range 1..15; 0 is illegal.
- i_clk  in  1  clock; all state changes on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  micro-op request.
- o_ready  out  1  sequencer can accept a request this cycle.
- i_src  in  2  bus source: 0 = reg0, 1 = reg1, 2 = external, 3 = none (illegal).
- i_dst  in  2  destination mask: bit0 = reg0, bit1 = reg1; 0 = no write, 3 = broadcast.
- o_ctrlRegBusSel  out  1  register transmitter select: 0 = reg0, 1 = reg1.
- o_ctrlRegBusNOE  out  1  register transmitter output enable, active low.
- o_ctrlExtBusNOE  out  1  external transmitter output enable, active low.
- o_ctrlReg0NWE  out  1  reg0 write enable, active low.
- o_ctrlReg1NWE  out  1  reg1 write enable, active low.
- o_done  out  1  one-cycle pulse when a micro-op completes.
- o_err  out  1  one-cycle pulse, coincident with o_done, for an illegal source.
- o_xferCount  out  8  completed-transfer counter.

## Operation
- States: IDLE, DRIVE, WRITE, HOLD.
- IDLE: o_ready = 1; all NOE/NWE high. On i_valid & o_ready, latch i_src/i_dst and go to DRIVE.
- DRIVE: if src is reg0/reg1, o_ctrlRegBusNOE = 0 and o_ctrlRegBusSel = src[0]; if src is external, o_ctrlExtBusNOE = 0. Stays SETTLE_CYCLES cycles (down-counter), then goes to WRITE.
- WRITE: source enable unchanged; o_ctrlReg0NWE = ~dst[0], o_ctrlReg1NWE = ~dst[1] for exactly one cycle. Goes to HOLD.
- HOLD: all NWE high; source enable still low; o_done = 1. Goes to IDLE.
- src = 3: no NOE is ever asserted and no NWE is asserted (a floating bus is never written); the sequence timing is unchanged; o_err pulses with o_done; o_xferCount does not increment.
- dst = 0: the bus is driven, no write strobe, o_done pulses, and o_xferCount increments.
- Self-copy (src = reg0, dst bit0 = 1) is legal and is sequenced normally.
- At most one NOE is low in any cycle; NOE and NWE never both change on the same edge in a way that would write an undriven bus.
- o_xferCount: increments by 1 on each legal o_done and wraps 255 -> 0.
- All outputs are registered; no combinational path from inputs to strobes.

## Timing
- Reset values: o_ready = 1, all NOE/NWE = 1, o_ctrlRegBusSel = 0, o_done = 0, o_err = 0, o_xferCount = 0, state IDLE.
- Accept edge = cycle 0. DRIVE occupies cycles 1..S (S = SETTLE_CYCLES). WRITE is cycle S+1; the destination captures on the edge ending cycle S+1. HOLD and o_done are at cycle S+2. IDLE with o_ready = 1 is at cycle S+3.
- Throughput: one micro-op per S+3 cycles. A request held on i_valid during a busy period is accepted at the first IDLE cycle.
- i_valid while o_ready = 0 is ignored; the request fields are sampled only on the accept edge.
- Reset asserted mid-operation: all strobes go high immediately (asynchronously), and the in-flight op is dropped with no o_done.

## Structure
- Shared package: source encodings (SRC_REG0, SRC_REG1, SRC_EXT, SRC_NONE), state enum, and the counter width derived from the SETTLE_CYCLES maximum.
- Single flat module; the settle down-counter stays inline and is not split into a sub-module.

## Test plan
- Reset then src = 0, dst = 2, S = 1: RegBusNOE low at cycles 1–3, Sel = 0, Reg1NWE low only at cycle 2, o_done at cycle 3, o_xferCount = 1.
- src = 2, dst = 3, S = 3: ExtBusNOE low at cycles 1–5, both NWE low only at cycle 4, RegBusNOE high throughout, o_done at cycle 5.
- src = 3, dst = 1: no strobe ever low, o_done and o_err at cycle S+2, o_xferCount unchanged.
- Back-to-back requests with i_valid held high: second accept at cycle S+3; 256 legal transfers leave o_xferCount = 0.
- Reset asserted during WRITE: Reg0NWE and RegBusNOE high before the next clock edge, state IDLE, no o_done, o_xferCount = 0.

Source files
------------

// File: rtl/regset_bus_sequencer_pkg.sv
// Shared encodings for the register-set bus sequencer: bus sources, FSM states
// and the settle-counter width.
package regset_bus_sequencer_pkg;

  localparam int SETTLE_MAX   = 15;
  localparam int SETTLE_CNT_W = $clog2(SETTLE_MAX + 1);

  typedef enum logic [1:0] {
    SRC_REG0 = 2'd0,
    SRC_REG1 = 2'd1,
    SRC_EXT  = 2'd2,
    SRC_NONE = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WRITE = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/regset_bus_sequencer.sv
// Initiator for register-set bus transfers: drives the source transmitter,
// lets the bus settle, strobes the destination write enables, then holds.
//
// state    | meaning
// ST_IDLE  | ready for a micro-op, all enables high
// ST_DRIVE | source transmitter enabled, settle down-counter running
// ST_WRITE | one-cycle destination write strobe, source still driving
// ST_HOLD  | write released, source still driving, done pulse
module regset_bus_sequencer
  import regset_bus_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [1:0] i_src,
  input  logic [1:0] i_dst,
  output logic       o_ctrlRegBusSel,
  output logic       o_ctrlRegBusNOE,
  output logic       o_ctrlExtBusNOE,
  output logic       o_ctrlReg0NWE,
  output logic       o_ctrlReg1NWE,
  output logic       o_done,
  output logic       o_err,
  output logic [7:0] o_xferCount
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
  src_e                    src_q, src_d;
  logic [1:0]              dst_q, dst_d;

  logic       ready_q, ready_d;
  logic       sel_q, sel_d;
  logic       reg_noe_q, reg_noe_d;
  logic       ext_noe_q, ext_noe_d;
  logic       nwe0_q, nwe0_d;
  logic       nwe1_q, nwe1_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] xfer_q, xfer_d;

  logic accept;
  assign accept = i_valid & ready_q;

  // State register plus output registers; reset forces every strobe inactive.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      src_q     <= SRC_NONE;
      dst_q     <= 2'b00;
      ready_q   <= 1'b1;
      sel_q     <= 1'b0;
      reg_noe_q <= 1'b1;
      ext_noe_q <= 1'b1;
      nwe0_q    <= 1'b1;
      nwe1_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      xfer_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      ready_q   <= ready_d;
      sel_q     <= sel_d;
      reg_noe_q <= reg_noe_d;
      ext_noe_q <= ext_noe_d;
      nwe0_q    <= nwe0_d;
      nwe1_q    <= nwe1_d;
      done_q    <= done_d;
      err_q     <= err_d;
      xfer_q    <= xfer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_DRIVE;
          cnt_d   = SETTLE_LOAD;
          src_d   = src_e'(i_src);
          dst_d   = i_dst;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) state_d = ST_WRITE;
        else             cnt_d   = cnt_q - SETTLE_CNT_W'(1);
      end
      ST_WRITE: state_d = ST_HOLD;
      ST_HOLD:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every strobe leaves a flop.
  always_comb begin
    ready_d   = (state_d == ST_IDLE);
    sel_d     = 1'b0;
    reg_noe_d = 1'b1;
    ext_noe_d = 1'b1;
    nwe0_d    = 1'b1;
    nwe1_d    = 1'b1;
    done_d    = 1'b0;
    err_d     = 1'b0;
    xfer_d    = xfer_q;
    if (state_d != ST_IDLE) begin
      if (src_d == SRC_REG0 || src_d == SRC_REG1) begin
        reg_noe_d = 1'b0;
        sel_d     = src_d[0];
      end else if (src_d == SRC_EXT) begin
        ext_noe_d = 1'b0;
      end
    end
    // A floating bus (no source) is never written.
    if (state_d == ST_WRITE && src_d != SRC_NONE) begin
      nwe0_d = ~dst_d[0];
      nwe1_d = ~dst_d[1];
    end
    if (state_d == ST_HOLD) begin
      done_d = 1'b1;
      err_d  = (src_d == SRC_NONE);
      if (src_d != SRC_NONE) xfer_d = xfer_q + 8'd1;
    end
  end

  assign o_ready         = ready_q;
  assign o_ctrlRegBusSel = sel_q;
  assign o_ctrlRegBusNOE = reg_noe_q;
  assign o_ctrlExtBusNOE = ext_noe_q;
  assign o_ctrlReg0NWE   = nwe0_q;
  assign o_ctrlReg1NWE   = nwe1_q;
  assign o_done          = done_q;
  assign o_err           = err_q;
  assign o_xferCount     = xfer_q;

endmodule

// File: tb/tb_regset_bus_sequencer.sv
// Bench for regset_bus_sequencer: two instances (settle 1 and 3) share stimulus
// and are compared every cycle against a phase-since-accept reference model.
module tb_regset_bus_sequencer;

  logic       clk;
  logic       i_reset;
  logic       i_valid;
  logic [1:0] i_src;
  logic [1:0] i_dst;

  logic [1:0] rdy, sel, rnoe, enoe, nwe0, nwe1, done, err;
  logic [7:0] cnt [2];

  int s_tab [2] = '{1, 3};

  // Model: ph = cycles since the accept edge (0 = idle).
  int         ph       [2];
  logic [1:0] msrc     [2];
  logic [1:0] mdst     [2];
  int         mcnt     [2];
  int         done_cnt [2];
  bit         wrap_mode;

  int n_checks;
  int n_errs;

  regset_bus_sequencer #(.SETTLE_CYCLES(1)) dut_s1 (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(rdy[0]),
    .i_src(i_src), .i_dst(i_dst), .o_ctrlRegBusSel(sel[0]),
    .o_ctrlRegBusNOE(rnoe[0]), .o_ctrlExtBusNOE(enoe[0]),
    .o_ctrlReg0NWE(nwe0[0]), .o_ctrlReg1NWE(nwe1[0]),
    .o_done(done[0]), .o_err(err[0]), .o_xferCount(cnt[0])
  );

  regset_bus_sequencer #(.SETTLE_CYCLES(3)) dut_s3 (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(rdy[1]),
    .i_src(i_src), .i_dst(i_dst), .o_ctrlRegBusSel(sel[1]),
    .o_ctrlRegBusNOE(rnoe[1]), .o_ctrlExtBusNOE(enoe[1]),
    .o_ctrlReg0NWE(nwe0[1]), .o_ctrlReg1NWE(nwe1[1]),
    .o_done(done[1]), .o_err(err[1]), .o_xferCount(cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int idx, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s[S=%0d] t=%0t got=%0d expected=%0d", tag, s_tab[idx], $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; msrc[i] = 2'd3; mdst[i] = 2'd0; mcnt[i] = 0; done_cnt[i] = 0;
    end
  endtask

  task automatic check_all();
    int  p, s;
    bit  legal, drv, wr, hold;
    for (int i = 0; i < 2; i++) begin
      p     = ph[i];
      s     = s_tab[i];
      legal = (msrc[i] != 2'd3);
      drv   = (p >= 1) && (p <= s + 2) && legal;
      wr    = (p == s + 1) && legal;
      hold  = (p == s + 2);
      check_val("ready",  i, int'(rdy[i]),  int'(p == 0));
      check_val("regnoe", i, int'(rnoe[i]), int'(!(drv && msrc[i] < 2'd2)));
      check_val("extnoe", i, int'(enoe[i]), int'(!(drv && msrc[i] == 2'd2)));
      check_val("sel",    i, int'(sel[i]),  int'(drv && msrc[i] == 2'd1));
      check_val("nwe0",   i, int'(nwe0[i]), int'(!(wr && mdst[i][0])));
      check_val("nwe1",   i, int'(nwe1[i]), int'(!(wr && mdst[i][1])));
      check_val("done",   i, int'(done[i]), int'(hold));
      check_val("err",    i, int'(err[i]),  int'(hold && !legal));
      check_val("count",  i, int'(cnt[i]),  mcnt[i]);
      if (wrap_mode && hold && done_cnt[i] == 256)
        check_val("wrap256", i, int'(cnt[i]), 0);
    end
  endtask

  // Apply inputs for the coming edge and advance the model across it.
  task automatic drive(input logic v, input logic [1:0] s, input logic [1:0] d);
    i_valid = v; i_src = s; i_dst = d;
    for (int i = 0; i < 2; i++) begin
      if (ph[i] == 0) begin
        if (v) begin ph[i] = 1; msrc[i] = s; mdst[i] = d; end
      end else begin
        ph[i]++;
        if (ph[i] == s_tab[i] + 2) begin
          done_cnt[i]++;
          if (msrc[i] != 2'd3) mcnt[i] = (mcnt[i] + 1) % 256;
        end else if (ph[i] > s_tab[i] + 2) begin
          ph[i] = 0;
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [1:0] s, input logic [1:0] d);
    @(negedge clk);
    check_all();
    drive(v, s, d);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(ph[0] == 0 && ph[1] == 0)) begin
      step(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      n++;
      if (n > 50) begin
        check_val("idle_timeout", 0, int'({rdy[1], rdy[0]}), 3);
        break;
      end
    end
  endtask

  logic [1:0] op_src [6] = '{2'd0, 2'd2, 2'd3, 2'd1, 2'd0, 2'd2};
  logic [1:0] op_dst [6] = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd1, 2'd0};

  initial begin
    int n;
    n_checks = 0; n_errs = 0; wrap_mode = 0;
    i_reset = 1'b1; i_valid = 1'b0; i_src = 2'd0; i_dst = 2'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    i_reset = 1'b0;
    drive(1'b0, 2'd0, 2'd0);

    // Directed ops: reg0->reg1, ext->both, none, reg1->nothing, self-copy, ext->nothing.
    for (int k = 0; k < 6; k++) begin
      wait_idle();
      step(1'b1, op_src[k], op_dst[k]);
    end
    wait_idle();

    // Random traffic, including requests presented while busy.
    for (int k = 0; k < 600; k++)
      step(1'(($urandom_range(0, 2)) != 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    wait_idle();

    // Reset asserted in the S=1 instance's WRITE cycle of a reg0->reg0 op.
    n = 0;
    forever begin
      @(negedge clk);
      check_all();
      if (ph[0] == s_tab[0] + 1) break;
      drive(1'b1, 2'd0, 2'd1);
      n++;
      if (n > 20) begin
        check_val("write_timeout", 0, int'(nwe0[0]), 0);
        break;
      end
    end
    check_val("pre_rst_nwe0", 0, int'(nwe0[0]), 0);
    i_reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    i_reset = 1'b0;
    drive(1'b0, 2'd0, 2'd0);

    // Back-to-back legal ops with valid held high until both wrap 255 -> 0.
    wrap_mode = 1;
    n = 0;
    while (!(done_cnt[0] > 256 && done_cnt[1] > 256)) begin
      step(1'b1, 2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)));
      n++;
      if (n > 4000) begin
        check_val("wrap_timeout", 1, int'(cnt[1]), 0);
        break;
      end
    end
    wrap_mode = 0;
    step(1'b0, 2'd0, 2'd0);
    wait_idle();
    step(1'b0, 2'd0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
